fpu_result_queue: RTL



---
 rtl/fpu_result_queue.sv | 120 ++++++++++++
 1 files changed

// File: rtl/fpu_result_queue.sv
// Show-ahead result FIFO behind the FPU result mux: tags entries with opcode, compare flags and class.
// Optional class tagging is enabled by defining FPU_RESQ_CLASS_EN; otherwise out_class is tied to zero.
module fpu_result_queue #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [2:0]                 in_opc,
  input  logic [31:0]                in_res,
  input  logic                       in_aeb,
  input  logic                       in_agb,
  input  logic                       in_alb,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_data,
  output logic [2:0]                 out_opc,
  output logic [2:0]                 out_cmp,
  output logic [3:0]                 out_class,
  output logic [$clog2(DEPTH):0]     count,
  input  logic                       clr_err,
  output logic                       err_ovf,
  output logic                       err_opc
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
`ifdef FPU_RESQ_CLASS_EN
  localparam int EW = 42;
`else
  localparam int EW = 38;
`endif

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          err_ovf_q, err_ovf_d;
  logic          err_opc_q, err_opc_d;
  logic [EW-1:0] mem_q [DEPTH];
  logic [EW-1:0] wr_entry;
  logic [EW-1:0] head;
  logic [2:0]    cmp_in;
  logic          full, empty, accept, push, pop;

  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == '0);
  assign in_ready  = !full;
  assign out_valid = !empty;
  assign count     = count_q;
  assign err_ovf   = err_ovf_q;
  assign err_opc   = err_opc_q;
  assign accept    = in_valid && !full;
  assign push      = accept && (in_opc <= 3'd4);
  assign pop       = !empty && out_ready;

  always_comb begin
    cmp_in = (in_opc == 3'd4) ? {in_aeb, in_agb, in_alb} : 3'b000;
`ifdef FPU_RESQ_CLASS_EN
    wr_entry = {in_res, in_opc, cmp_in, 4'b0000};
    if (in_opc != 3'd4) begin
      wr_entry[3] = (in_res[30:23] == 8'hFF) && (in_res[22:0] != '0);
      wr_entry[2] = (in_res[30:23] == 8'hFF) && (in_res[22:0] == '0);
      wr_entry[1] = (in_res[30:23] == 8'h00) && (in_res[22:0] == '0);
      wr_entry[0] = in_res[31];
    end
`else
    wr_entry = {in_res, in_opc, cmp_in};
`endif
  end

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    err_ovf_d = (in_valid && full) || (err_ovf_q && !clr_err);
    err_opc_d = (accept && (in_opc > 3'd4)) || (err_opc_q && !clr_err);
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      err_ovf_q <= 1'b0;
      err_opc_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      err_ovf_q <= err_ovf_d;
      err_opc_q <= err_opc_d;
    end
  end

  // Storage is deliberately left unreset; a write during reset is harmless since pointers clear.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_entry;
  end

  always_comb begin
    head      = out_valid ? mem_q[rd_ptr_q] : '0;
    out_data  = head[EW-1 -: 32];
    out_opc   = head[EW-33 -: 3];
    out_cmp   = head[EW-36 -: 3];
`ifdef FPU_RESQ_CLASS_EN
    out_class = head[3:0];
`else
    out_class = 4'b0000;
`endif
  end

endmodule
